// File: rtl/cgra_config_pkg.sv
// cgra_config_pkg: shared parameters, opcodes, register offsets, FSM states.
// Used by cgra_top and cgra_instr_mem.
package cgra_config_pkg;

  localparam int N_CORES          = 2;
  localparam int ID               = 2;
  localparam int INSTR_WIDTH      = 32;
  localparam int RC_INSTR_N_REG   = 32;
  localparam int KER_CONF_N_REG   = 16;
  localparam int WR_INSTR_ADD_LEN = 8;
  localparam int N_COLS           = 4;
  localparam int PC_W             = 5;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LD   = 4'd1,
    OP_ADDI = 4'd2,
    OP_ST   = 4'd3,
    OP_EXIT = 4'd4
  } opcode_e;

  localparam logic [7:0] REG_KER_ID = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_PTR0   = 8'h08;
  localparam logic [7:0] REG_PTR1   = 8'h0C;
  localparam logic [7:0] REG_PTR2   = 8'h10;
  localparam logic [7:0] REG_PTR3   = 8'h14;
  localparam logic [7:0] REG_PERF   = 8'h18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MEM   = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] apply_be(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cgra_instr_mem.sv
// cgra_instr_mem: per-column instruction store and kernel config table.
// Ports: clk_i, program write (we/waddr/wdata), pc_i -> instr_o, ker_id_i -> ker_conf_o.
module cgra_instr_mem
  import cgra_config_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                we_i,
  input  logic [WR_INSTR_ADD_LEN-1:0]         waddr_i,
  input  logic [INSTR_WIDTH-1:0]              wdata_i,
  input  logic [PC_W-1:0]                     pc_i,
  output logic [N_COLS-1:0][INSTR_WIDTH-1:0]  instr_o,
  input  logic [3:0]                          ker_id_i,
  output logic [INSTR_WIDTH-1:0]              ker_conf_o
);

  logic [INSTR_WIDTH-1:0] instr_mem    [N_COLS][RC_INSTR_N_REG];
  logic [INSTR_WIDTH-1:0] ker_conf_mem [KER_CONF_N_REG];

  // No reset: contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (!waddr_i[7]) begin
        instr_mem[waddr_i[6:5]][waddr_i[4:0]] <= wdata_i;
      end else if (waddr_i[6:4] == 3'b000) begin
        ker_conf_mem[waddr_i[3:0]] <= wdata_i;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N_COLS; c++) begin
      instr_o[c] = instr_mem[c][pc_i];
    end
  end

  assign ker_conf_o = ker_conf_mem[ker_id_i];

endmodule

// File: rtl/cgra_top.sv
// cgra_top: 4-column lockstep CGRA; periph slave, one TCDM master per column.
// Optional macro CGRA_PERF_CNT_EN adds a busy-cycle counter at offset 0x18.
module cgra_top
  import cgra_config_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          periph_req_i,
  input  logic                          periph_enable_i,
  input  logic                          periph_wen_i,
  input  logic [31:0]                   periph_add_i,
  input  logic [31:0]                   periph_wdata_i,
  input  logic [3:0]                    periph_be_i,
  input  logic [ID-1:0]                 periph_id_i,
  output logic                          periph_gnt_o,
  output logic                          periph_r_valid_o,
  output logic [31:0]                   periph_rdata_o,
  output logic [ID-1:0]                 periph_r_id_o,
  output logic [N_COLS-1:0]             tcdm_req_o,
  output logic [N_COLS-1:0]             tcdm_wen_o,
  output logic [N_COLS-1:0][31:0]       tcdm_add_o,
  output logic [N_COLS-1:0][31:0]       tcdm_wdata_o,
  output logic [N_COLS-1:0][3:0]        tcdm_be_o,
  input  logic [N_COLS-1:0]             tcdm_gnt_i,
  input  logic [N_COLS-1:0]             tcdm_r_valid_i,
  input  logic [N_COLS-1:0][31:0]       tcdm_rdata_i,
  input  logic [WR_INSTR_ADD_LEN-1:0]   instr_waddr_i,
  input  logic [INSTR_WIDTH-1:0]        instr_wdata_i,
  input  logic                          instr_we_i,
  output logic [N_CORES-1:0]            evt_o
);

  state_e                         r_state;
  logic [PC_W-1:0]                r_pc;
  logic [PC_W-1:0]                r_end_pc;
  logic                           r_req_id;
  logic                           r_exit;
  logic [N_COLS-1:0][31:0]        r_acc;
  logic [N_COLS-1:0][31:0]        r_ptr;
  logic [N_COLS-1:0][31:0]        r_add;
  logic [N_COLS-1:0][31:0]        r_wdata;
  logic [N_COLS-1:0]              r_req;
  logic [N_COLS-1:0]              r_pend;
  logic [N_COLS-1:0]              r_wen;
  logic [N_CORES-1:0]             r_evt;
  logic                           r_rvalid;
  logic [31:0]                    r_rdata;
  logic [ID-1:0]                  r_rid;

  logic [N_COLS-1:0][INSTR_WIDTH-1:0] w_instr;
  logic [N_COLS-1:0][3:0]         w_op;
  logic [N_COLS-1:0][31:0]        w_sext;
  logic [INSTR_WIDTH-1:0]         w_conf;
  logic                           w_gnt;
  logic                           w_wr;
  logic                           w_busy;
  logic                           w_start;
  logic [7:0]                     w_off;
  logic [31:0]                    w_rd;
  logic                           w_unused;

  cgra_instr_mem cgra_instr_mem_i (
    .clk_i      (clk_i),
    .we_i       (instr_we_i),
    .waddr_i    (instr_waddr_i),
    .wdata_i    (instr_wdata_i),
    .pc_i       (r_pc),
    .instr_o    (w_instr),
    .ker_id_i   (periph_wdata_i[3:0]),
    .ker_conf_o (w_conf)
  );

  // Grant is forced low while reset is held.
  assign w_gnt   = periph_req_i & periph_enable_i & rst_i;
  assign w_wr    = w_gnt & ~periph_wen_i;
  assign w_off   = periph_add_i[7:0];
  assign w_busy  = (r_state != IDLE);
  assign w_start = w_wr && (w_off == REG_KER_ID) && periph_be_i[0]
                   && (periph_wdata_i[3:0] != 4'd0) && !w_busy;

  always_comb begin
    for (int c = 0; c < N_COLS; c++) begin
      w_op[c]   = w_instr[c][31:28];
      w_sext[c] = {{16{w_instr[c][15]}}, w_instr[c][15:0]};
    end
  end

  assign w_unused = ^{periph_add_i[31:8], w_conf[31:10], w_instr};

`ifdef CGRA_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_perf <= '0;
    end else if (w_start) begin
      r_perf <= '0;
    end else if (w_busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end
`endif

  always_comb begin
    w_rd = '0;
    case (w_off)
      REG_STATUS: w_rd = {31'd0, w_busy};
      REG_PTR0:   w_rd = r_ptr[0];
      REG_PTR1:   w_rd = r_ptr[1];
      REG_PTR2:   w_rd = r_ptr[2];
      REG_PTR3:   w_rd = r_ptr[3];
`ifdef CGRA_PERF_CNT_EN
      REG_PERF:   w_rd = r_perf;
`endif
      default:    w_rd = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_end_pc <= '0;
      r_req_id <= 1'b0;
      r_exit   <= 1'b0;
      r_acc    <= '0;
      r_ptr    <= '0;
      r_add    <= '0;
      r_wdata  <= '0;
      r_req    <= '0;
      r_pend   <= '0;
      r_wen    <= '0;
      r_evt    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rid    <= '0;
    end else begin
      r_rvalid <= w_gnt;
      r_rdata  <= (w_gnt && periph_wen_i) ? w_rd : 32'd0;
      if (w_gnt) r_rid <= periph_id_i;
      r_evt <= '0;
      case (r_state)
        IDLE: begin
          for (int c = 0; c < N_COLS; c++) begin
            if (w_wr && (w_off == REG_PTR0 + 8'(4 * c))) begin
              r_ptr[c] <= apply_be(r_ptr[c], periph_wdata_i,
                                   periph_be_i);
            end
          end
          if (w_start) begin
            r_pc     <= w_conf[4:0];
            r_end_pc <= w_conf[9:5];
            r_req_id <= periph_id_i[0];
            r_exit   <= 1'b0;
            r_state  <= FETCH;
          end
        end
        FETCH: begin
          for (int c = 0; c < N_COLS; c++) begin
            case (w_op[c])
              OP_LD: begin
                r_req[c]  <= 1'b1;
                r_pend[c] <= 1'b1;
                r_wen[c]  <= 1'b1;
                r_add[c]  <= r_ptr[c];
              end
              OP_ST: begin
                r_req[c]   <= 1'b1;
                r_pend[c]  <= 1'b1;
                r_wen[c]   <= 1'b0;
                r_add[c]   <= r_ptr[c];
                r_wdata[c] <= r_acc[c];
              end
              OP_ADDI: r_acc[c] <= r_acc[c] + w_sext[c];
              OP_EXIT: r_exit <= 1'b1;
              default: ;
            endcase
          end
          r_state <= MEM;
        end
        MEM: begin
          for (int c = 0; c < N_COLS; c++) begin
            if (r_req[c] && tcdm_gnt_i[c]) r_req[c] <= 1'b0;
            if (r_pend[c] && tcdm_r_valid_i[c]) begin
              r_pend[c] <= 1'b0;
              r_ptr[c]  <= r_ptr[c] + 32'd4;
              if (r_wen[c]) r_acc[c] <= tcdm_rdata_i[c];
            end
          end
          // Step retires once no column has an op outstanding.
          if (r_pend == '0) begin
            if (r_exit || (r_pc >= r_end_pc)) begin
              r_state <= DONE;
            end else begin
              r_pc    <= r_pc + 5'd1;
              r_state <= FETCH;
            end
          end
        end
        DONE: begin
          r_evt[r_req_id] <= 1'b1;
          r_state         <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < N_COLS; c++) begin
      tcdm_be_o[c] = r_req[c] ? 4'hF : 4'h0;
    end
  end

  assign periph_gnt_o     = w_gnt;
  assign periph_r_valid_o = r_rvalid;
  assign periph_rdata_o   = r_rdata;
  assign periph_r_id_o    = r_rid;
  assign tcdm_req_o       = r_req;
  assign tcdm_wen_o       = r_wen;
  assign tcdm_add_o       = r_add;
  assign tcdm_wdata_o     = r_wdata;
  assign evt_o            = r_evt;

endmodule

// File: tb/tb_cgra_top.sv
// tb_cgra_top: directed + random kernels vs. a step-level reference model.
// Includes a TCDM memory responder with per-column grant delay.
module tb_cgra_top;
  import cgra_config_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              p_req = 0, p_en = 0, p_wen = 1;
  logic [31:0]       p_add = '0, p_wdata = '0;
  logic [3:0]        p_be = '0;
  logic [1:0]        p_id = '0;
  logic              p_gnt, p_rv;
  logic [31:0]       p_rdata;
  logic [1:0]        p_rid;
  logic [3:0]        t_req, t_wen;
  logic [3:0][31:0]  t_add, t_wdata;
  logic [3:0][3:0]   t_be;
  logic [3:0]        t_gnt = '0, t_rv = '0;
  logic [3:0][31:0]  t_rdata = '0;
  logic [7:0]        i_waddr = '0;
  logic [31:0]       i_wdata = '0;
  logic              i_we = 1'b0;
  logic [1:0]        evt;

  int checks = 0;
  int errors = 0;

  cgra_top dut (
    .clk_i(clk), .rst_i(rst),
    .periph_req_i(p_req), .periph_enable_i(p_en), .periph_wen_i(p_wen),
    .periph_add_i(p_add), .periph_wdata_i(p_wdata), .periph_be_i(p_be),
    .periph_id_i(p_id), .periph_gnt_o(p_gnt), .periph_r_valid_o(p_rv),
    .periph_rdata_o(p_rdata), .periph_r_id_o(p_rid),
    .tcdm_req_o(t_req), .tcdm_wen_o(t_wen), .tcdm_add_o(t_add),
    .tcdm_wdata_o(t_wdata), .tcdm_be_o(t_be), .tcdm_gnt_i(t_gnt),
    .tcdm_r_valid_i(t_rv), .tcdm_rdata_i(t_rdata),
    .instr_waddr_i(i_waddr), .instr_wdata_i(i_wdata), .instr_we_i(i_we),
    .evt_o(evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memories: DUT-facing and model ----------------
  logic [31:0] tmem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];

  function automatic logic [31:0] deflt(input logic [31:0] a);
    return a ^ 32'h00C3_5A11;
  endfunction

  // ---------------- TCDM responder ----------------
  int          dly [4];
  int          wcnt [4];
  bit          pend_rv [4];
  logic [31:0] pend_d [4];
  bit          seen [4];
  logic [31:0] h_add [4];
  logic [31:0] h_wd [4];
  logic        h_wen [4];

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (!rst) begin
        t_gnt[c] = 0; t_rv[c] = 0; t_rdata[c] = '0;
        wcnt[c] = 0; pend_rv[c] = 0; seen[c] = 0;
      end else begin
        t_rv[c] = 0;
        t_rdata[c] = '0;
        if (pend_rv[c]) begin
          t_rv[c] = 1; t_rdata[c] = pend_d[c]; pend_rv[c] = 0;
        end
        if (t_gnt[c]) begin
          t_gnt[c] = 0;
          chk("req_drop_after_gnt", 32'(t_req[c]), 32'd0);
        end else if (t_req[c]) begin
          chk("req_be", 32'(t_be[c]), 32'hF);
          if (!seen[c]) begin
            seen[c] = 1; h_add[c] = t_add[c];
            h_wd[c] = t_wdata[c]; h_wen[c] = t_wen[c];
          end else begin
            chk("req_stable_add", t_add[c], h_add[c]);
            chk("req_stable_wdata", t_wdata[c], h_wd[c]);
            chk("req_stable_wen", 32'(t_wen[c]), 32'(h_wen[c]));
          end
          if (wcnt[c] >= dly[c]) begin
            t_gnt[c] = 1; wcnt[c] = 0; seen[c] = 0; pend_rv[c] = 1;
            if (t_wen[c]) begin
              pend_d[c] = tmem.exists(t_add[c]) ? tmem[t_add[c]]
                                                : deflt(t_add[c]);
            end else begin
              tmem[t_add[c]] = t_wdata[c];
              pend_d[c] = '0;
            end
          end else begin
            wcnt[c]++;
          end
        end
      end
    end
  end

  int evt_cnt [2];
  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) if (evt[b]) evt_cnt[b]++;
  end

  // ---------------- reference model ----------------
  logic [31:0] pgm [4][32];
  logic [31:0] kconf [16];
  logic [31:0] macc [4];
  logic [31:0] mptr [4];

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : deflt(a);
  endfunction

  task automatic model_kernel(input int k);
    int s, e, pc;
    bit ex;
    s = int'(kconf[k][4:0]);
    e = int'(kconf[k][9:5]);
    pc = s;
    while (1) begin
      ex = 0;
      for (int c = 0; c < 4; c++) begin
        logic [31:0] ins;
        ins = pgm[c][pc];
        case (int'(ins[31:28]))
          1: begin macc[c] = mrd(mptr[c]); mptr[c] += 4; end
          2: macc[c] += {{16{ins[15]}}, ins[15:0]};
          3: begin mmem[mptr[c]] = macc[c]; mptr[c] += 4; end
          4: ex = 1;
          default: ;
        endcase
      end
      if (ex || pc >= e) break;
      pc++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic periph(input logic wen, input logic [31:0] add,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [1:0] id, output logic [31:0] rd);
    p_req = 1; p_en = 1; p_wen = wen; p_add = add;
    p_wdata = wd; p_be = be; p_id = id;
    #1 chk("periph_gnt", 32'(p_gnt), 32'd1);
    @(negedge clk);
    p_req = 0; p_en = 0;
    chk("periph_rvalid", 32'(p_rv), 32'd1);
    chk("periph_rid", 32'(p_rid), 32'(id));
    rd = p_rdata;
  endtask

  task automatic wr(input logic [31:0] add, input logic [31:0] wd,
                    input logic [1:0] id);
    logic [31:0] d;
    periph(1'b0, add, wd, 4'hF, id, d);
  endtask

  task automatic rd(input logic [31:0] add, output logic [31:0] d);
    periph(1'b1, add, 32'd0, 4'hF, 2'd3, d);
  endtask

  task automatic set_ptr(input int c, input logic [31:0] v);
    wr(32'h08 + 32'(4 * c), v, 2'd0);
    mptr[c] = v;
  endtask

  task automatic load_instr(input logic [7:0] a, input logic [31:0] d);
    i_we = 1; i_waddr = a; i_wdata = d;
    @(negedge clk);
    i_we = 0;
  endtask

  task automatic write_all();
    for (int c = 0; c < 4; c++)
      for (int e = 0; e < 32; e++)
        load_instr(8'(c * 32 + e), pgm[c][e]);
  endtask

  task automatic write_conf(input int k);
    load_instr(8'(128 + k), kconf[k]);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    tmem[a] = v; mmem[a] = v;
  endtask

  int  cur_k, busy_cyc;
  bit  cur_b;
  int  e_before [2];

  task automatic start_k(input int k, input logic [1:0] id);
    cur_k = k; cur_b = id[0];
    e_before[0] = evt_cnt[0]; e_before[1] = evt_cnt[1];
    wr(32'h00, 32'(k), id);
  endtask

  task automatic finish_k(input string tag);
    bit got;
    logic [31:0] d;
    got = 0; busy_cyc = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      busy_cyc++;
      if (evt[cur_b]) got = 1;
    end
    chk({tag, "_evt_seen"}, 32'(got), 32'd1);
    model_kernel(cur_k);
    tick(3);
    chk({tag, "_evt_once"}, 32'(evt_cnt[cur_b]),
        32'(e_before[cur_b] + 1));
    chk({tag, "_evt_other"}, 32'(evt_cnt[!cur_b]),
        32'(e_before[!cur_b]));
    rd(32'h04, d);
    chk({tag, "_status_idle"}, d, 32'd0);
    chk({tag, "_mem_size"}, 32'(tmem.num()), 32'(mmem.num()));
    foreach (mmem[a])
      chk({tag, "_mem"}, tmem.exists(a) ? tmem[a] : ~mmem[a], mmem[a]);
    for (int c = 0; c < 4; c++) begin
      rd(32'h08 + 32'(4 * c), d);
      chk({tag, "_ptr"}, d, mptr[c]);
    end
  endtask

  function automatic logic [31:0] ins(input int op, input int imm);
    return {4'(op), 12'h0, 16'(imm)};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] d;
    for (int c = 0; c < 4; c++) begin
      dly[c] = 0; macc[c] = '0; mptr[c] = '0;
      for (int e = 0; e < 32; e++) pgm[c][e] = '0;
    end
    for (int k = 0; k < 16; k++) kconf[k] = '0;

    // reset state
    tick(2);
    p_req = 1; p_en = 1;
    #1;
    chk("rst_gnt", 32'(p_gnt), 32'd0);
    chk("rst_rvalid", 32'(p_rv), 32'd0);
    chk("rst_rdata", p_rdata, 32'd0);
    chk("rst_evt", 32'(evt), 32'd0);
    chk("rst_tcdm_req", 32'(t_req), 32'd0);
    chk("rst_tcdm_add0", t_add[0], 32'd0);
    @(negedge clk);
    p_req = 0; p_en = 0; rst = 1;
    tick(1);

    // periph write/read of a column pointer
    wr(32'h08, 32'h1000, 2'd2);
    rd(32'h08, d);
    chk("ptr0_readback", d, 32'h1000);
    mptr[0] = 32'h1000;

    // byte enables
    wr(32'h0C, 32'hFFFF_FFFF, 2'd1);
    periph(1'b0, 32'h0C, 32'h1234_5678, 4'b0101, 2'd1, d);
    rd(32'h0C, d);
    chk("byte_enable", d, 32'hFF34_FF78);
    set_ptr(1, 32'h2000);
    set_ptr(2, 32'h3000);
    set_ptr(3, 32'h4000);
    rd(32'h04, d);
    chk("status_idle", d, 32'd0);
    rd(32'h1C, d);
    chk("unmapped_reads_0", d, 32'd0);
`ifndef CGRA_PERF_CNT_EN
    rd(32'h18, d);
    chk("perf_absent_reads_0", d, 32'd0);
`endif

    // basic kernel: LD, ADDI 5, ST on column 0
    pgm[0][0] = ins(1, 0);
    pgm[0][1] = ins(2, 5);
    pgm[0][2] = ins(3, 0);
    kconf[1] = (32'd2 << 5) | 32'd0;
    write_all();
    write_conf(1);
    preload(32'h1000, 32'd7);
    start_k(1, 2'd1);
    finish_k("basic");
    chk("basic_store_12", tmem[32'h1004], 32'd12);

    // all columns, column 2 grant delayed by 3
    for (int c = 0; c < 4; c++) begin
      pgm[c][0] = ins(1, 0);
      pgm[c][1] = ins(2, c + 1);
      pgm[c][2] = ins(3, 0);
    end
    write_all();
    dly[2] = 3;
    start_k(1, 2'd0);
    finish_k("stall");

    // start and pointer write while busy are ignored
    start_k(1, 2'd2);
    tick(2);
    wr(32'h00, 32'd1, 2'd1);
    wr(32'h08, 32'hDEAD_0000, 2'd1);
    finish_k("busy_start");

    // program-port write during execution hits next fetch
    start_k(1, 2'd0);
    load_instr(8'd1, ins(2, 100));
    pgm[0][1] = ins(2, 100);
    finish_k("live_prog");

    // end PC below start PC: only start step runs
    for (int c = 0; c < 4; c++) begin
      pgm[c][5] = ins(3, 0);
      pgm[c][6] = ins(3, 0);
      pgm[c][8] = ins(1, 0);
      pgm[c][9] = ins(c == 3 ? 4 : 3, 0);
      pgm[c][10] = ins(3, 0);
    end
    kconf[2] = (32'd1 << 5) | 32'd5;
    kconf[3] = (32'd12 << 5) | 32'd8;
    write_all();
    write_conf(2);
    write_conf(3);
    start_k(2, 2'd1);
    finish_k("no_wrap");

    // EXIT in one column ends the kernel
    start_k(3, 2'd0);
    finish_k("exit");

    // random kernels
    for (int it = 0; it < 6; it++) begin
      int s;
      for (int c = 0; c < 4; c++) begin
        dly[c] = $urandom_range(0, 3);
        set_ptr(c, 32'((c + 1) << 16) + 32'($urandom_range(0, 255) << 2));
        for (int e = 0; e < 32; e++) begin
          int r, op;
          r = $urandom_range(0, 9);
          op = (r < 2) ? 0 : (r < 4) ? 1 : (r < 6) ? 2 : (r < 8) ? 3 :
               (r == 8) ? 7 : (($urandom_range(0, 3) == 0) ? 4 : 2);
          pgm[c][e] = {4'(op), 12'($urandom), 16'($urandom)};
        end
      end
      s = $urandom_range(0, 31);
      kconf[4] = {22'd0,
                  ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'(s + $urandom_range(0, 31 - s)),
                  5'(s)};
      write_all();
      write_conf(4);
      start_k(4, 2'($urandom_range(0, 3)));
      finish_k("random");
    end

`ifdef CGRA_PERF_CNT_EN
    for (int c = 0; c < 4; c++) begin
      dly[c] = 1;
      pgm[c][0] = ins(1, 0);
      pgm[c][1] = ins(3, 0);
      pgm[c][2] = ins(1, 0);
    end
    kconf[5] = (32'd2 << 5) | 32'd0;
    write_all();
    write_conf(5);
    start_k(5, 2'd0);
    finish_k("perf");
    rd(32'h18, d);
    chk("perf_nonzero", 32'(d != 0), 32'd1);
    chk("perf_busy_cycles", d, 32'(busy_cyc));
`endif

    // reset mid-kernel: outputs clear at once, no event
    for (int c = 0; c < 4; c++) dly[c] = 3;
    start_k(1, 2'd1);
    tick(4);
    p_req = 1; p_en = 1;
    rst = 0;
    #1;
    chk("mid_rst_tcdm_req", 32'(t_req), 32'd0);
    chk("mid_rst_tcdm_add", 32'(|t_add), 32'd0);
    chk("mid_rst_tcdm_wdata", 32'(|t_wdata), 32'd0);
    chk("mid_rst_tcdm_be", 32'(|t_be), 32'd0);
    chk("mid_rst_gnt", 32'(p_gnt), 32'd0);
    chk("mid_rst_rvalid", 32'(p_rv), 32'd0);
    chk("mid_rst_rdata", p_rdata, 32'd0);
    chk("mid_rst_evt", 32'(evt), 32'd0);
    p_req = 0; p_en = 0;
    tick(2);
    rst = 1;
    tick(1);
    rd(32'h04, d);
    chk("mid_rst_status", d, 32'd0);
    rd(32'h08, d);
    chk("mid_rst_ptr_cleared", d, 32'd0);
    tick(60);
    chk("mid_rst_no_evt0", 32'(evt_cnt[0]), 32'(e_before[0]));
    chk("mid_rst_no_evt1", 32'(evt_cnt[1]), 32'(e_before[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
